rf_writeback_port: RTL and testbench

// - Write side of the 64-bit NPC integer register file: buffers in-order writeback requests from WB stage.
// - Drains one write per cycle into register storage; reports pending (not yet written) registers for hazard checks.
// - Sits between the WB stage (valid/ready) and the register storage write port.

---
 rtl/rf_writeback_port.sv | 182 ++++++++++++++++++
 tb/tb_rf_writeback_port.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_port.sv
// ---------------------------------------------------------------------------
// rf_writeback_port
//
// Purpose:
//   Write side of the 64-bit integer register file. In-order writeback
//   requests from the WB stage are buffered in a small circular queue. They
//   are drained one per cycle through a registered output stage into the
//   register storage write port. The block also reports which registers
//   still have a write pending, for hazard detection.
//
// Optional feature (compile-time macro RF_WB_FWD_EN):
//   When defined, chk_hit/chk_data forward the youngest pending value for
//   chk_addr. When undefined, both outputs are tied to zero and no
//   forwarding mux is built.
//
// Ports:
//   clk       in   1       clock, all state updates on posedge
//   rst_n     in   1       asynchronous active-low reset
//   wb_valid  in   1       writeback request valid
//   wb_ready  out  1       queue can accept a request this cycle
//   wb_addr   in   ADDR_W  destination register index
//   wb_data   in   DATA_W  writeback value
//   rf_wen    out  1       write strobe to register storage (registered)
//   rf_waddr  out  ADDR_W  write index (registered)
//   rf_wdata  out  DATA_W  write data (registered)
//   rf_ready  in   1       storage accepts rf_* this cycle
//   chk_addr  in   ADDR_W  hazard-query register index
//   chk_busy  out  1       chk_addr has a pending write (combinational)
//   chk_hit   out  1       forwarded data valid (forwarding builds only)
//   chk_data  out  DATA_W  forwarded value (forwarding builds only)
// ---------------------------------------------------------------------------
module rf_writeback_port #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_busy,
    output logic              chk_hit,
    output logic [DATA_W-1:0] chk_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue control and storage
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];

    // Output register stage
    logic              r_wen_p1;
    logic [ADDR_W-1:0] r_waddr_p1;
    logic [DATA_W-1:0] r_wdata_p1;

    logic w_ready;
    logic w_accept;
    logic w_push;
    logic w_org_load;
    logic w_pop;
    logic w_busy;

    // Ready depends only on occupancy, so a full queue never takes a new
    // entry even in a cycle where the head is being drained.
    assign w_ready    = (r_count != FULL_CNT);
    assign w_accept   = wb_valid && w_ready;
    // Writes to x0 complete the handshake but are never stored.
    assign w_push     = w_accept && (wb_addr != '0);
    assign w_org_load = !r_wen_p1 || rf_ready;
    assign w_pop      = w_org_load && (r_count != '0);

    // ---- Stage p0: queue control (pointers and occupancy) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; entries are only ever read when the
    // pointers and count mark them valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= wb_addr;
            r_q_data[r_wr_ptr] <= wb_data;
        end
    end

    // ---- Stage p1: output register toward register storage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen_p1   <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
        end else if (w_org_load) begin
            if (r_count != '0) begin
                r_wen_p1   <= 1'b1;
                r_waddr_p1 <= r_q_addr[r_rd_ptr];
                r_wdata_p1 <= r_q_data[r_rd_ptr];
            end else begin
                // Address and data hold their last value while idle.
                r_wen_p1 <= 1'b0;
            end
        end
    end

    // Hazard query: the output register plus every valid queue entry.
    // An entry at offset k from the head is valid when k < count.
    always_comb begin
        w_busy = r_wen_p1 && (r_waddr_p1 == chk_addr);
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_q_addr[r_rd_ptr + PTR_W'(k)] == chk_addr)) begin
                w_busy = 1'b1;
            end
        end
        if (chk_addr == '0) begin
            w_busy = 1'b0;
        end
    end

    assign wb_ready = w_ready;
    assign rf_wen   = r_wen_p1;
    assign rf_waddr = r_waddr_p1;
    assign rf_wdata = r_wdata_p1;
    assign chk_busy = w_busy;

`ifdef RF_WB_FWD_EN
    logic [DATA_W-1:0] w_fwd_data;

    // Priority runs oldest to youngest so the last match wins: the output
    // register is the oldest pending write, the queue tail the youngest.
    always_comb begin
        w_fwd_data = '0;
        if (r_wen_p1 && (r_waddr_p1 == chk_addr)) begin
            w_fwd_data = r_wdata_p1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_q_addr[r_rd_ptr + PTR_W'(k)] == chk_addr)) begin
                w_fwd_data = r_q_data[r_rd_ptr + PTR_W'(k)];
            end
        end
        if (!w_busy) begin
            w_fwd_data = '0;
        end
    end

    assign chk_hit  = w_busy;
    assign chk_data = w_fwd_data;
`else
    assign chk_hit  = 1'b0;
    assign chk_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_port.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_port
//
// The driver applies directed sequences followed by random traffic. The
// checker keeps an abstract model of the block: a list of writes waiting
// behind the output register, plus the write currently presented to
// storage. It also keeps a scoreboard of every accepted write in order.
// Each storage write the DUT performs pops the scoreboard and is compared.
// ---------------------------------------------------------------------------
module tb_rf_writeback_port;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk;
    logic              rst_n;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_busy;
    logic              chk_hit;
    logic [DATA_W-1:0] chk_data;

    int n_vec = 0;
    int n_err = 0;

    rf_writeback_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rf_ready (rf_ready),
        .chk_addr (chk_addr),
        .chk_busy (chk_busy),
        .chk_hit  (chk_hit),
        .chk_data (chk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    ent_t wait_q[$];   // accepted, not yet in the output register
    ent_t sb_q[$];     // every accepted non-x0 write, in order
    ent_t org;
    bit   org_v = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wait_q.delete();
                sb_q.delete();
                org_v = 0;
                check("rst_wen", {63'd0, rf_wen}, 64'd0);
                check("rst_ready", {63'd0, wb_ready}, 64'd1);
                check("rst_busy", {63'd0, chk_busy}, 64'd0);
            end else begin
                bit   exp_busy;
                logic [DATA_W-1:0] exp_fwd;
                bit   ready_m;
                exp_busy = 0;
                exp_fwd  = '0;
                if (chk_addr != 0) begin
                    for (int i = wait_q.size() - 1; i >= 0; i--) begin
                        if (!exp_busy && wait_q[i].a == chk_addr) begin
                            exp_busy = 1;
                            exp_fwd  = wait_q[i].d;
                        end
                    end
                    if (!exp_busy && org_v && org.a == chk_addr) begin
                        exp_busy = 1;
                        exp_fwd  = org.d;
                    end
                end
                ready_m = (wait_q.size() != DEPTH);

                check("wb_ready", {63'd0, wb_ready}, {63'd0, ready_m});
                check("rf_wen", {63'd0, rf_wen}, {63'd0, org_v});
                if (org_v) begin
                    check("rf_waddr", {59'd0, rf_waddr}, {59'd0, org.a});
                    check("rf_wdata", rf_wdata, org.d);
                end
                check("chk_busy", {63'd0, chk_busy}, {63'd0, exp_busy});
`ifdef RF_WB_FWD_EN
                check("chk_hit", {63'd0, chk_hit}, {63'd0, exp_busy});
                if (exp_busy) check("chk_data", chk_data, exp_fwd);
`else
                check("chk_hit", {63'd0, chk_hit}, 64'd0);
                check("chk_data", chk_data, 64'd0);
`endif

                // Storage write about to happen on the coming edge.
                if (rf_wen && rf_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_write", {59'd0, rf_waddr}, 64'd0);
                        n_err++;
                    end else begin
                        ent_t e;
                        e = sb_q.pop_front();
                        check("sb_addr", {59'd0, rf_waddr}, {59'd0, e.a});
                        check("sb_data", rf_wdata, e.d);
                    end
                end

                // Model state for the coming edge: drain first, then accept.
                if (!org_v || rf_ready) begin
                    if (wait_q.size() > 0) begin
                        org   = wait_q.pop_front();
                        org_v = 1;
                    end else begin
                        org_v = 0;
                    end
                end
                if (wb_valid && ready_m && wb_addr != 0) begin
                    ent_t n;
                    n.a = wb_addr;
                    n.d = wb_data;
                    wait_q.push_back(n);
                    sb_q.push_back(n);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input bit v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit rdy,
                       input logic [ADDR_W-1:0] q);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        rf_ready = rdy;
        chk_addr = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rf_ready = 1'b1;
        chk_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 5);

        // Single write, query the same register while it drains.
        cyc(1, 5, 64'hdead_beef, 1, 5);
        repeat (4) cyc(0, 0, 0, 1, 5);

        // Fill: output register takes addr 1, queue holds 2..5.
        for (int i = 1; i <= 6; i++) cyc(1, ADDR_W'(i), 64'(i * 16), 0, ADDR_W'(i));
        check("full_ready", {63'd0, wb_ready}, 64'd0);
        repeat (8) cyc(0, 0, 0, 1, 3);

        // x0 write is discarded.
        cyc(1, 0, 64'd1, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        // Same register twice: younger value forwards.
        cyc(1, 7, 64'd1, 0, 7);
        cyc(1, 7, 64'd2, 0, 7);
        repeat (2) cyc(0, 0, 0, 0, 7);
        repeat (5) cyc(0, 0, 0, 1, 7);

        // Reset with writes in flight: nothing may reach storage.
        for (int i = 1; i <= 4; i++) cyc(1, ADDR_W'(i + 8), 64'(i), 0, 9);
        rst_n = 1'b0;
        cyc(0, 0, 0, 1, 9);
        cyc(0, 0, 0, 1, 10);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 1, 9);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) < 60,
                ADDR_W'($urandom_range(0, 7)),
                {$urandom, $urandom},
                $urandom_range(0, 99) < 70,
                ADDR_W'($urandom_range(0, 7)));
        end

        // Bounded drain.
        begin
            int budget;
            budget = 0;
            while ((sb_q.size() != 0 || rf_wen) && budget < 20) begin
                cyc(0, 0, 0, 1, 0);
                budget++;
            end
            check("drain_empty", 64'(sb_q.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
